// File: rtl/ysyx_23060236_rdarb_pkg.sv
// Shared definitions for the read arbiter: FSM state encodings and requester indices.
package ysyx_23060236_rdarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam int IFU = 0;
  localparam int LSU = 1;
  localparam int PTW = 2;

endpackage

// File: rtl/ysyx_23060236_rr_pick.sv
// Round-robin picker: one-hot grant to the first set request at or after ptr, wrapping.
module ysyx_23060236_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the last hit is the highest-priority one.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060236_rdarb.sv
// N-way round-robin AXI4 read arbiter, one transaction outstanding.
// Optional perf counters enabled by defining YSYX_23060236_RDARB_PERF_EN.
module ysyx_23060236_rdarb
  import ysyx_23060236_rdarb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int TOW  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_arvalid,
  output logic [NREQ-1:0]     req_arready,
  input  logic [32*NREQ-1:0]  req_araddr,
  input  logic [8*NREQ-1:0]   req_arlen,
  input  logic [3*NREQ-1:0]   req_arsize,
  input  logic [2*NREQ-1:0]   req_arburst,
  output logic [NREQ-1:0]     req_rvalid,
  input  logic [NREQ-1:0]     req_rready,
  output logic [31:0]         req_rdata,
  output logic [1:0]          req_rresp,
  output logic                req_rlast,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [31:0]         m_araddr,
  output logic [3:0]          m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [31:0]         m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic [3:0]          m_rid
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  rd_state_e       state;
  logic [GW-1:0]   rr, gidx, gsel;
  logic [NREQ-1:0] gnt;
  logic            dsel;

  ysyx_23060236_rr_pick #(.N(NREQ), .PW(GW)) u_pick (
    .req (req_arvalid),
    .ptr (rr),
    .gnt (gnt)
  );

  always_comb begin
    gsel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gsel = GW'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr        <= '0;
      gidx      <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (|req_arvalid) begin
          gidx      <= gsel;
          m_araddr  <= req_araddr[32*gsel +: 32];
          m_arlen   <= req_arlen[8*gsel +: 8];
          m_arsize  <= req_arsize[3*gsel +: 3];
          m_arburst <= req_arburst[2*gsel +: 2];
          state     <= ST_ADDR;
        end
        ST_ADDR: if (m_arready) state <= ST_DATA;
        ST_DATA: if (m_rvalid && m_rready && m_rlast) begin
          state <= ST_IDLE;
          rr    <= (gidx == GW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Grant is combinational so the requester sees arready in the cycle it asks.
  assign req_arready = (state == ST_IDLE && !reset) ? gnt : '0;
  assign m_arvalid   = (state == ST_ADDR);
  assign m_arid      = 4'(gidx);

  assign dsel = (state == ST_DATA) && !reset;

  always_comb begin
    req_rvalid = '0;
    if (dsel) req_rvalid[gidx] = m_rvalid;
  end

  assign m_rready  = dsel & req_rready[gidx];
  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;

`ifdef YSYX_23060236_RDARB_PERF_EN
  logic [NREQ-1:0][31:0]    grant_cnt;
  logic [NREQ-1:0][TOW-1:0] max_wait;
  logic [NREQ-1:0][TOW-1:0] cur_wait;

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt <= '0;
      max_wait  <= '0;
      cur_wait  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_arready[i]) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
          if (cur_wait[i] > max_wait[i]) max_wait[i] <= cur_wait[i];
          cur_wait[i] <= '0;
        end else if (req_arvalid[i] && cur_wait[i] != '1) begin
          cur_wait[i] <= cur_wait[i] + 1'b1;
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^m_rid;
`else
  logic unused_ok;
  assign unused_ok = ^{m_rid, 1'(TOW)};
`endif

endmodule

// File: tb/tb_ysyx_23060236_rdarb.sv
// Bench for ysyx_23060236_rdarb: directed scenarios plus random traffic against a round-robin model.
module tb_ysyx_23060236_rdarb;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_arvalid, req_arready, req_rvalid, req_rready;
  logic [95:0] req_araddr;
  logic [23:0] req_arlen;
  logic [8:0]  req_arsize;
  logic [5:0]  req_arburst;
  logic [31:0] req_rdata, m_araddr, m_rdata;
  logic [1:0]  req_rresp, m_arburst, m_rresp;
  logic        req_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;

  ysyx_23060236_rdarb #(.NREQ(3), .TOW(8)) dut (
    .clock(clock), .reset(reset),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_arsize(req_arsize), .req_arburst(req_arburst),
    .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata),
    .req_rresp(req_rresp), .req_rlast(req_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  // Reference model: pending requests, their fields, and the round-robin pointer.
  logic [2:0]  pend;
  logic [31:0] m_addr [3];
  logic [7:0]  m_len  [3];
  logic [2:0]  m_size [3];
  logic [1:0]  m_burst[3];
  int          rr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int r, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [1:0] b);
    m_addr[r] = a; m_len[r] = l; m_size[r] = s; m_burst[r] = b;
    req_araddr[32*r +: 32] = a;
    req_arlen[8*r +: 8]    = l;
    req_arsize[3*r +: 3]   = s;
    req_arburst[2*r +: 2]  = b;
    req_arvalid[r] = 1'b1;
    pend[r] = 1'b1;
  endtask

  // Called at a negedge with the DUT idle and at least one request pending.
  task automatic do_txn(input int ar_delay, input int stall_beat, input int stall_len,
                        input int abort_at);
    int g;
    logic [2:0] oh;
    logic [31:0] d;
    logic [1:0] rs;
    int beats;
    g = -1;
    for (int k = 0; k < 3; k++)
      if (g < 0 && pend[(rr_m + k) % 3]) g = (rr_m + k) % 3;
    oh = 3'b001 << g;
    #1 chk("arready_grant", 64'(req_arready), 64'(oh));
    @(negedge clock);
    req_arvalid[g] = 1'b0;
    pend[g] = 1'b0;
    chk("m_arvalid_lat", 64'(m_arvalid), 64'd1);
    chk("m_arid", 64'(m_arid), 64'(g));
    chk("m_araddr", 64'(m_araddr), 64'(m_addr[g]));
    chk("m_arlen", 64'(m_arlen), 64'(m_len[g]));
    chk("m_arsize", 64'(m_arsize), 64'(m_size[g]));
    chk("m_arburst", 64'(m_arburst), 64'(m_burst[g]));
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clock);
      chk("ar_hold_valid", 64'(m_arvalid), 64'd1);
      chk("ar_hold_addr", 64'(m_araddr), 64'(m_addr[g]));
      chk("ar_hold_len", 64'(m_arlen), 64'(m_len[g]));
      chk("ar_busy_arready", 64'(req_arready), 64'd0);
    end
    m_arready = 1'b1;
    @(negedge clock);
    m_arready = 1'b0;
    beats = 0;
    for (int b = 0; b <= int'(m_len[g]); b++) begin
      d = $urandom;
      rs = 2'($urandom);
      m_rvalid = 1'b1; m_rdata = d; m_rresp = rs; m_rlast = (b == int'(m_len[g]));
      m_rid = 4'(g);
      req_rready = 3'($urandom) & ~oh;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk("stall_m_rready", 64'(m_rready), 64'd0);
          chk("stall_rvalid", 64'(req_rvalid), 64'(oh));
          chk("stall_rdata", 64'(req_rdata), 64'(d));
          @(negedge clock);
        end
      end
      req_rready[g] = 1'b1;
      #1;
      chk("beat_rvalid", 64'(req_rvalid), 64'(oh));
      chk("beat_m_rready", 64'(m_rready), 64'd1);
      chk("beat_rdata", 64'(req_rdata), 64'(d));
      chk("beat_rresp", 64'(req_rresp), 64'(rs));
      chk("beat_rlast", 64'(req_rlast), 64'(b == int'(m_len[g])));
      chk("data_arready", 64'(req_arready), 64'd0);
      if (m_rready && req_rvalid[g]) beats++;
      @(negedge clock);
      req_rready = 3'b000; m_rvalid = 1'b0; m_rlast = 1'b0;
      if (b == abort_at) begin
        reset = 1'b1; m_rvalid = 1'b1; req_rready = 3'b111;
        @(negedge clock);
        #1;
        chk("rst_arready", 64'(req_arready), 64'd0);
        chk("rst_rvalid", 64'(req_rvalid), 64'd0);
        chk("rst_m_rready", 64'(m_rready), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr), 64'd0);
        reset = 1'b0; m_rvalid = 1'b0; req_rready = 3'b000;
        rr_m = 0;
        return;
      end
    end
    chk("beat_count", 64'(beats), 64'(int'(m_len[g]) + 1));
    rr_m = (g + 1) % 3;
    // Back in idle: a stray R beat must not reach any requester.
    m_rvalid = 1'b1; req_rready = 3'b111;
    #1;
    chk("idle_rvalid", 64'(req_rvalid), 64'd0);
    chk("idle_m_rready", 64'(m_rready), 64'd0);
    chk("idle_m_arvalid", 64'(m_arvalid), 64'd0);
    m_rvalid = 1'b0; req_rready = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] s;
    reset = 1'b1;
    req_arvalid = 3'b111; req_rready = 3'b111;
    req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arburst = '0;
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    pend = '0; rr_m = 0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_arready", 64'(req_arready), 64'd0);
    chk("reset_rvalid", 64'(req_rvalid), 64'd0);
    chk("reset_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("reset_m_rready", 64'(m_rready), 64'd0);
    chk("reset_m_araddr", 64'(m_araddr), 64'd0);
    chk("reset_m_arlen", 64'(m_arlen), 64'd0);
    req_arvalid = 3'b000; req_rready = 3'b000; m_rvalid = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // Single lsu read, immediate arready.
    raise(1, 32'h8000_0010, 8'd0, 3'd2, 2'd1);
    do_txn(0, -1, 0, -1);
    // ifu burst of four.
    raise(0, 32'h3000_0000, 8'd3, 3'd2, 2'd1);
    do_txn(0, -1, 0, -1);
    // ptw burst with a 5-cycle requester stall mid-burst.
    raise(2, 32'h0000_1000, 8'd3, 3'd2, 2'd1);
    do_txn(0, 1, 5, -1);
    // AR held off for 10 cycles while another requester waits.
    raise(0, 32'h1234_5678, 8'd0, 3'd1, 2'd0);
    raise(2, 32'h0000_2000, 8'd1, 3'd2, 2'd1);
    do_txn(10, -1, 0, -1);
    do_txn(0, -1, 0, -1);
    // All three at once from pointer 0, then 0 again after wrap.
    raise(0, 32'hA000_0000, 8'd1, 3'd2, 2'd1);
    raise(1, 32'hB000_0000, 8'd0, 3'd2, 2'd1);
    raise(2, 32'hC000_0000, 8'd2, 3'd2, 2'd1);
    do_txn(0, -1, 0, -1);
    do_txn(0, -1, 0, -1);
    do_txn(0, -1, 0, -1);
    raise(0, 32'hA000_0100, 8'd0, 3'd2, 2'd1);
    do_txn(0, -1, 0, -1);
    // Reset during beat 2 of 4; pointer must come back to 0.
    raise(1, 32'hD000_0000, 8'd3, 3'd2, 2'd1);
    raise(0, 32'hE000_0000, 8'd0, 3'd2, 2'd1);
    raise(2, 32'hF000_0000, 8'd1, 3'd2, 2'd1);
    do_txn(0, -1, 0, 1);
    pend[1] = 1'b0;
    do_txn(0, -1, 0, -1);
    do_txn(0, -1, 0, -1);

    for (int it = 0; it < 30; it++) begin
      if (pend == 3'b000) begin
        s = 3'($urandom_range(1, 7));
        for (int r = 0; r < 3; r++)
          if (s[r]) raise(r, $urandom, 8'($urandom_range(0, 4)),
                          3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
      end
      do_txn($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
